// File: rtl/as_ctrl.sv
// as_ctrl -- FETCH/EXEC/HALT sequencer for a small accumulator/register datapath.
//
// Fetches 20-bit instruction words over a request/acknowledge port and decodes
// them into one cycle of ALU/register-file control, or several cycles for
// WAITSW. Instruction layout: op=[19:16], rd=[14:12], rs=[10:8], imm=[7:0].
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   imem_req/imem_addr    fetch request and address (address is always PC)
//   imem_ack/imem_data    fetch completion and instruction word
//   z                     ALU zero flag, consulted by BZ/BNZ/WAITSW
//   rd_addr, rs_addr      register file addresses (rd is also write address)
//   immediate             IR.imm, zero-extended or truncated to n bits
//   add_a_sel .. reg_we   datapath controls, active only in EXEC
//   halted                high in HALT
//   illegal               sticky flag set by opcodes 10-14
module as_ctrl #(
  parameter int n  = 8,
  parameter int pw = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [pw-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [19:0]   imem_data,
  input  logic          z,
  output logic [2:0]    rd_addr,
  output logic [2:0]    rs_addr,
  output logic [n-1:0]  immediate,
  output logic          add_a_sel,
  output logic          add_b_sel,
  output logic          acc_en,
  output logic          acc_add,
  output logic          in_en,
  output logic          reg_we,
  output logic          halted,
  output logic          illegal
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_ADDI   = 4'd2;
  localparam logic [3:0] OP_MACC   = 4'd3;
  localparam logic [3:0] OP_LDACC  = 4'd4;
  localparam logic [3:0] OP_IN     = 4'd5;
  localparam logic [3:0] OP_BZ     = 4'd6;
  localparam logic [3:0] OP_BNZ    = 4'd7;
  localparam logic [3:0] OP_J      = 4'd8;
  localparam logic [3:0] OP_WAITSW = 4'd9;
  localparam logic [3:0] OP_HALT   = 4'd15;

  state_t        state_q, state_d;
  logic [pw-1:0] pc_q, pc_d;
  logic [19:0]   ir_q, ir_d;
  logic          illegal_q, illegal_d;

  logic [3:0]    op;
  logic [n-1:0]  imm_ext;
  logic [pw-1:0] target;
  logic [pw-1:0] pc_inc;

  // Bits 15 and 11 of the instruction carry no meaning.
  logic unused_ir_bits;
  assign unused_ir_bits = ir_q[15] ^ ir_q[11];

  assign op     = ir_q[19:16];
  assign pc_inc = pc_q + pw'(1);  // natural wrap from 2^pw-1 to 0

  // The 8-bit immediate feeds both the datapath (n bits) and the branch
  // target (pw bits); each is zero-extended or truncated independently.
  generate
    if (n > 8) begin : g_imm_wide
      assign imm_ext = {{(n-8){1'b0}}, ir_q[7:0]};
    end else begin : g_imm_narrow
      assign imm_ext = ir_q[n-1:0];
    end
    if (pw > 8) begin : g_tgt_wide
      assign target = {{(pw-8){1'b0}}, ir_q[7:0]};
    end else begin : g_tgt_narrow
      assign target = ir_q[pw-1:0];
    end
  endgenerate

  assign imem_addr = pc_q;
  assign illegal   = illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    rd_addr   = '0;
    rs_addr   = '0;
    immediate = '0;
    add_a_sel = 1'b0;
    add_b_sel = 1'b0;
    acc_en    = 1'b0;
    acc_add   = 1'b0;
    in_en     = 1'b0;
    reg_we    = 1'b0;
    halted    = 1'b0;

    // Outputs are forced quiet during reset whatever the current state; the
    // next-state values are irrelevant then because the register resets.
    if (!reset) begin
      unique case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_d    = imem_data;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          rd_addr   = ir_q[14:12];
          rs_addr   = ir_q[10:8];
          immediate = imm_ext;
          state_d   = S_FETCH;
          pc_d      = pc_inc;
          case (op)
            OP_ADD:   reg_we = 1'b1;
            OP_ADDI:  begin add_b_sel = 1'b1; reg_we = 1'b1; end
            OP_MACC:  begin acc_en = 1'b1; acc_add = 1'b1; end
            OP_LDACC: begin add_b_sel = 1'b1; acc_en = 1'b1; end
            OP_IN:    begin in_en = 1'b1; reg_we = 1'b1; end
            OP_BZ:    if (z) pc_d = target;
            OP_BNZ:   if (!z) pc_d = target;
            OP_J:     pc_d = target;
            OP_WAITSW: begin
              add_a_sel = 1'b1;
              rs_addr   = 3'd0;
              // Spin in EXEC with controls held until the zero flag drops.
              if (z) begin
                state_d = S_EXEC;
                pc_d    = pc_q;
              end
            end
            OP_HALT: begin
              state_d = S_HALT;
              pc_d    = pc_q;
            end
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14: illegal_d = 1'b1;
            default: ;  // NOP
          endcase
        end
        S_HALT: halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_as_ctrl.sv
// Testbench for as_ctrl: a bench-side instruction memory with per-address
// acknowledge delay and scripted zero flag, an instruction-level reference
// model checked every cycle, and directed literal expectations.
module tb_as_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [19:0] imem_data;
  logic        z;
  logic [2:0]  rd_addr, rs_addr;
  logic [7:0]  immediate;
  logic        add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we;
  logic        halted, illegal;

  int checks = 0;
  int errors = 0;

  as_ctrl #(.n(8), .pw(8)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .z(z),
    .rd_addr(rd_addr), .rs_addr(rs_addr), .immediate(immediate),
    .add_a_sel(add_a_sel), .add_b_sel(add_b_sel),
    .acc_en(acc_en), .acc_add(acc_add), .in_en(in_en), .reg_we(reg_we),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- program memory and responder ----------------
  logic [19:0] mem [256];
  int          delay_tbl [256];
  bit          z_val [256];
  int          z_hold [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 20'h00000; delay_tbl[i] = 0; z_val[i] = 1'b0; z_hold[i] = 0;
    end
    mem[0]   = 20'h22006;                     // ADDI rd=2 imm=6
    mem[1]   = 20'h60028; delay_tbl[1] = 5;   // BZ 40, z=1 -> taken
    z_val[1] = 1'b1;
    mem[40]  = 20'h60028;                     // BZ 40, z=0 -> fall through
    mem[41]  = 20'h93511; z_hold[41] = 3;     // WAITSW rd=3 rs=5
    mem[42]  = 20'h800FA;                     // J 250
    mem[250] = 20'hCF7FF;                     // illegal opcode 12
    mem[251] = 20'h32100;                     // MACC
    mem[252] = 20'h40055;                     // LDACC
    mem[253] = 20'h57000;                     // IN
    mem[254] = 20'h1F9AB;                     // ADD, bits 15/11 set
    mem[255] = 20'h00000;                     // NOP, PC wraps
  end

  // Acknowledges after delay_tbl[addr] waiting cycles. When no request is
  // outstanding it drives a stray acknowledge with junk data, which the DUT
  // must ignore. z is 1 during fetches, and in EXEC follows the script.
  initial begin
    int wait_cnt = 0;
    int hold_left = 0;
    logic [7:0] cur_addr = 8'd0;
    imem_ack = 1'b0; imem_data = 20'h0; z = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (imem_req === 1'b1) begin
        z = 1'b1;
        if (wait_cnt >= delay_tbl[imem_addr]) begin
          imem_ack = 1'b1; imem_data = mem[imem_addr];
          cur_addr = imem_addr; hold_left = z_hold[imem_addr]; wait_cnt = 0;
        end else begin
          imem_ack = 1'b0; imem_data = 20'hFFFFF; wait_cnt++;
        end
      end else begin
        imem_ack = 1'b1; imem_data = 20'hFFFFF; wait_cnt = 0;
        if (hold_left > 0) begin z = 1'b1; hold_left--; end
        else z = z_val[cur_addr];
      end
    end
  end

  // ---------------- reference model ----------------
  // Modes: 0 waiting for an instruction, 1 executing, 2 stopped.
  initial begin
    int          m_mode = 0;
    int          m_pc = 0;
    logic [19:0] m_ir = 20'h0;
    bit          m_ill = 1'b0;
    logic [5:0]  ctl_of [16];
    logic [5:0]  e_ctl;
    logic [2:0]  e_rd, e_rs;
    logic [7:0]  e_imm;
    bit          e_req, e_halt;
    int          op;
    for (int i = 0; i < 16; i++) ctl_of[i] = 6'b0;
    // {add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we}
    ctl_of[1] = 6'b000001;
    ctl_of[2] = 6'b010001;
    ctl_of[3] = 6'b001100;
    ctl_of[4] = 6'b011000;
    ctl_of[5] = 6'b000011;
    ctl_of[9] = 6'b100000;
    forever begin
      @(negedge clk);
      op = int'(m_ir[19:16]);
      e_req = 0; e_halt = 0; e_ctl = '0; e_rd = '0; e_rs = '0; e_imm = '0;
      if (reset !== 1'b1) begin
        if (m_mode == 0) e_req = 1;
        else if (m_mode == 2) e_halt = 1;
        else begin
          e_ctl = ctl_of[op];
          e_rd  = m_ir[14:12];
          e_rs  = (op == 9) ? 3'd0 : m_ir[10:8];
          e_imm = m_ir[7:0];
        end
      end
      check("imem_req", imem_req, e_req);
      check("imem_addr", imem_addr, m_pc);
      check("controls", {add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we}, e_ctl);
      check("rd_addr", rd_addr, e_rd);
      check("rs_addr", rs_addr, e_rs);
      check("immediate", immediate, e_imm);
      check("halted", halted, e_halt);
      check("illegal", illegal, m_ill);
      // Advance to the state seen after the coming rising edge.
      if (reset === 1'b1) begin
        m_mode = 0; m_pc = 0; m_ir = 20'h0; m_ill = 0;
      end else if (m_mode == 0) begin
        if (imem_ack === 1'b1) begin m_ir = imem_data; m_mode = 1; end
      end else if (m_mode == 1) begin
        m_mode = 0;
        case (op)
          6:  m_pc = z ? int'(m_ir[7:0]) : (m_pc + 1) % 256;
          7:  m_pc = !z ? int'(m_ir[7:0]) : (m_pc + 1) % 256;
          8:  m_pc = int'(m_ir[7:0]);
          9:  if (z) m_mode = 1; else m_pc = (m_pc + 1) % 256;
          15: m_mode = 2;
          default: begin
            if (op >= 10) m_ill = 1;
            m_pc = (m_pc + 1) % 256;
          end
        endcase
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  // Steps to the first cycle of the next fetch; returns its address, or -1.
  task automatic next_fetch(output int a);
    int k = 0;
    a = -1;
    while (imem_req === 1'b1 && k < 100) begin tick(); k++; end
    while (imem_req !== 1'b1 && k < 100) begin tick(); k++; end
    if (k >= 100) begin
      checks++; errors++;
      $display("FAIL next_fetch: got timeout expected a fetch within 100 cycles");
    end else a = int'(imem_addr);
  endtask

  initial begin
    int a, cnt, rs_bad;
    int seq [5] = '{252, 253, 254, 255, 0};
    reset = 1'b1;
    tick(); tick();
    check("reset_req", imem_req, 0);
    check("reset_halted", halted, 0);
    @(posedge clk); #1 reset = 1'b0;

    tick();
    check("first_fetch_req", imem_req, 1);
    check("first_fetch_addr", imem_addr, 0);
    tick();
    check("addi_add_b_sel", add_b_sel, 1);
    check("addi_reg_we", reg_we, 1);
    check("addi_rd", rd_addr, 2);
    check("addi_imm", immediate, 6);
    tick();
    check("fetch_after_addi", imem_addr, 1);

    // Slow acknowledge: request held steady for 6 cycles.
    cnt = 1;
    while (cnt < 20) begin
      tick();
      if (imem_req === 1'b1 && imem_addr == 8'd1) cnt++;
      else break;
    end
    check("slow_ack_req_cycles", cnt, 6);
    next_fetch(a);
    check("bz_taken_target", a, 40);
    mem[0] = 20'hF0000;  // second pass through address 0 halts
    next_fetch(a);
    check("bz_not_taken", a, 41);

    cnt = 0; rs_bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_req === 1'b1) break;
      if (add_a_sel === 1'b1) cnt++;
      if (rs_addr !== 3'd0) rs_bad++;
    end
    check("waitsw_cycles", cnt, 4);
    check("waitsw_rs_zero", rs_bad, 0);
    check("waitsw_next_addr", imem_addr, 42);

    next_fetch(a);
    check("jump_target", a, 250);
    next_fetch(a);
    check("after_illegal_addr", a, 251);
    check("illegal_set", illegal, 1);
    for (int i = 0; i < 5; i++) begin
      next_fetch(a);
      check("seq_addr", a, seq[i]);
    end
    check("illegal_sticky", illegal, 1);

    for (int i = 0; i < 11; i++) tick();
    check("halt_halted", halted, 1);
    check("halt_req", imem_req, 0);
    check("halt_addr", imem_addr, 0);

    // Reset out of HALT, then reset in the middle of a stalled fetch.
    @(posedge clk); #1 reset = 1'b1;
    tick();
    check("reset_in_halt_req", imem_req, 0);
    check("reset_in_halt_halted", halted, 0);
    mem[0] = 20'h22006;
    delay_tbl[0] = 50;
    @(posedge clk); #1 reset = 1'b0;
    tick();
    check("post_halt_reset_req", imem_req, 1);
    check("post_halt_reset_addr", imem_addr, 0);
    check("post_halt_reset_halted", halted, 0);
    check("post_halt_reset_illegal", illegal, 0);
    for (int i = 0; i < 5; i++) tick();
    @(posedge clk); #1 reset = 1'b1;
    tick();
    check("midfetch_reset_req", imem_req, 0);
    @(posedge clk); #1 reset = 1'b0;
    delay_tbl[0] = 0;
    tick();
    check("midfetch_after_req", imem_req, 1);
    check("midfetch_after_addr", imem_addr, 0);
    tick();
    check("final_addi_reg_we", reg_we, 1);
    check("final_addi_rd", rd_addr, 2);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    checks++; errors++;
    $display("FAIL watchdog: got timeout expected completion before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/as_ctrl.md
AS_CTRL -- requirements
Module: as_ctrl

Interface
REQ-001 The module SHALL have parameter n, default 8, datapath width of immediate.
REQ-002 The module SHALL have parameter pw, default 8, program counter / instruction address width.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port imem_req  output  1  instruction fetch request.
REQ-006 Port imem_addr  output  pw  fetch address, equals PC.
REQ-007 Port imem_ack  input  1  fetch complete; imem_data valid this cycle.
REQ-008 Port imem_data  input  20  instruction word.
REQ-009 Port z  input  1  ALU zero flag.
REQ-010 Port rd_addr, rs_addr  output  3 each  register file read addresses; rd_addr is also the write address.
REQ-011 Port immediate  output  n  immediate operand to ALU.
REQ-012 Ports add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we  output  1 each  ALU/regfile controls.
REQ-013 Port halted  output  1  high while in HALT.
REQ-014 Port illegal  output  1  sticky illegal-opcode flag.

Function
REQ-015 Instruction fields SHALL be: op=[19:16], rd=[14:12], rs=[10:8], imm=[7:0]; bits 15 and 11 are ignored.
REQ-016 States SHALL be FETCH, EXEC, HALT; encoding free.
REQ-017 In FETCH: imem_req=1 and imem_addr=PC held until imem_ack; on ack, IR<=imem_data and next state is EXEC; imem_ack with imem_req low SHALL be ignored.
REQ-018 Fetch latency SHALL be unbounded: no timeout, with PC and IR stable while waiting.
REQ-019 EXEC SHALL last exactly one cycle, except WAITSW; control outputs SHALL be nonzero only in EXEC.
REQ-020 In EXEC, rd_addr=IR.rd, rs_addr=IR.rs, immediate=IR.imm, zero-extended to n if n>8 and truncated if n<8; in all other states these outputs are 0.
REQ-021 Opcodes, with all unlisted controls 0:
 - 0 NOP: none.
 - 1 ADD: reg_we.
 - 2 ADDI: add_b_sel, reg_we.
 - 3 MACC: acc_en, acc_add.
 - 4 LDACC: add_b_sel, acc_en.
 - 5 IN: in_en, reg_we.
 - 6 BZ: none; taken if z=1.
 - 7 BNZ: none; taken if z=0.
 - 8 J: none; always taken.
 - 9 WAITSW: add_a_sel, with rs_addr forced to 0.
 - 15 HALT: none.
REQ-022 Taken branch or jump target SHALL be IR.imm[pw-1:0]; otherwise PC<=PC+1, wrapping from 2^pw-1 to 0.
REQ-023 z SHALL be sampled in the EXEC cycle of BZ, BNZ and WAITSW only.
REQ-024 WAITSW SHALL remain in EXEC with controls held while z=1, and SHALL advance PC and go to FETCH on the first EXEC cycle with z=0.
REQ-025 HALT SHALL enter the HALT state without advancing PC; HALT SHALL be left only by reset; halted=1 in HALT.
REQ-026 Opcodes 10-14 SHALL behave as NOP and set illegal=1 from the next cycle until reset.
REQ-027 Every EXEC exit other than to HALT SHALL go to FETCH; minimum throughput is one instruction per 2 cycles when imem_ack is returned in the same cycle as the request.

Reset
REQ-028 While reset=1 at a rising edge: state<=FETCH, PC<=0, IR<=0, illegal<=0.
REQ-029 imem_req and all control outputs SHALL be 0 in any cycle with reset=1, regardless of state; halted=0 after reset.
REQ-030 Reset SHALL take priority in any state, including mid-fetch, in EXEC and in HALT; the first fetch after reset is from address 0.

Verification
REQ-031 Reset, then ack immediately with ADDI rd=2 imm=6 (0x22006) -> EXEC cycle: add_b_sel=1, reg_we=1, rd_addr=2, immediate=6; next fetch at address 1.
REQ-032 Delay imem_ack by 5 cycles -> imem_req=1 and imem_addr=0 stable for 6 cycles; no control pulses during the wait.
REQ-033 BZ imm=40 with z=1 -> next imem_addr=40; same instruction with z=0 -> next imem_addr=PC+1.
REQ-034 WAITSW with z held 1 for 3 cycles then 0 -> add_a_sel=1 and rs_addr=0 for 4 cycles, then FETCH at PC+1.
REQ-035 PC=255 executing NOP -> next imem_addr=0; opcode 12 -> illegal=1 and sticky, reg_we/acc_en stay 0.
REQ-036 HALT -> halted=1 and imem_req=0 indefinitely; assert reset mid-fetch or in HALT -> next cycle FETCH at address 0, halted=0, illegal=0.
